// File: rtl/pipe_mem_sched.sv
// pipe_mem_sched: arbitrates the shared main memory between I-line fills,
// D-line fills and write-through stores, and drives the pipeline stage
// enables, flushes and bubbles for memory stalls, load-use, branches and halt.
module pipe_mem_sched #(
    parameter  int unsigned BLK_WORDS = 8,
    localparam int unsigned IDX_W     = $clog2(BLK_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_miss,
    input  logic [15:0]      i_blk_addr,
    input  logic             d_miss,
    input  logic [15:0]      d_blk_addr,
    input  logic             d_wr_req,
    input  logic [15:0]      d_wr_addr,
    input  logic [15:0]      d_wr_data,
    input  logic             mem_rd_valid,
    input  logic             ex_mem_read,
    input  logic [3:0]       ex_dst,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             br_taken,
    input  logic             wb_halt,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             fill_we,
    output logic             fill_tgt,
    output logic [IDX_W-1:0] fill_idx,
    output logic             i_fill_done,
    output logic             d_fill_done,
    output logic             d_wr_ack,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble
);

    localparam int unsigned AW    = 16;
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] ISS_END  = CNT_W'(BLK_WORDS);
    localparam logic [IDX_W-1:0] RET_LAST = IDX_W'(BLK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_D = 2'd1,
        FILL_I = 2'd2
    } state_t;

    state_t            state;
    logic [AW-1:0]     blk_base;
    logic [CNT_W-1:0]  iss_cnt;
    logic [IDX_W-1:0]  ret_cnt;
    logic              halt_q;

    logic              st_req;
    logic              dm_req;
    logic              im_req;
    logic [AW-1:0]     grant_base;
    logic              dstall;
    logic              istall;
    logic              lu;

    // Request qualification: a request whose ack/done is being pulsed this
    // cycle is already served; the requester drops it at the next edge.
    always_comb begin
        st_req     = d_wr_req & ~d_wr_ack;
        dm_req     = d_miss & ~d_fill_done;
        im_req     = i_miss & ~i_fill_done;
        grant_base = dm_req ? d_blk_addr : i_blk_addr;
    end

    // Memory FSM with registered memory/fill outputs; issue runs one step ahead
    // so that mem_en/mem_addr come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            blk_base    <= '0;
            iss_cnt     <= '0;
            ret_cnt     <= '0;
            halt_q      <= 1'b0;
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fill_we     <= 1'b0;
            fill_tgt    <= 1'b0;
            fill_idx    <= '0;
            i_fill_done <= 1'b0;
            d_fill_done <= 1'b0;
            d_wr_ack    <= 1'b0;
        end else begin
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            fill_we     <= 1'b0;
            i_fill_done <= 1'b0;
            d_fill_done <= 1'b0;
            d_wr_ack    <= 1'b0;
            if (wb_halt) begin
                halt_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (st_req) begin
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= d_wr_addr;
                        mem_wdata <= d_wr_data;
                        d_wr_ack  <= 1'b1;
                    end else if (dm_req | im_req) begin
                        state    <= dm_req ? FILL_D : FILL_I;
                        fill_tgt <= dm_req;
                        blk_base <= grant_base;
                        mem_en   <= 1'b1;
                        mem_addr <= grant_base;
                        iss_cnt  <= CNT_W'(1);
                        ret_cnt  <= '0;
                    end
                end
                FILL_D, FILL_I: begin
                    if (iss_cnt < ISS_END) begin
                        mem_en   <= 1'b1;
                        mem_addr <= blk_base + AW'({iss_cnt, 1'b0});
                        iss_cnt  <= iss_cnt + CNT_W'(1);
                    end
                    if (mem_rd_valid) begin
                        fill_we  <= 1'b1;
                        fill_idx <= ret_cnt;
                        ret_cnt  <= ret_cnt + IDX_W'(1);
                        if (ret_cnt == RET_LAST) begin
                            state <= IDLE;
                            if (state == FILL_D) begin
                                d_fill_done <= 1'b1;
                            end else begin
                                i_fill_done <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage enable / flush / bubble decode, highest priority first.
    always_comb begin
        dstall = d_miss | d_wr_req | (state == FILL_D);
        istall = i_miss | (state == FILL_I);
        lu     = ex_mem_read & (ex_dst != 4'd0) &
                 ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));

        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;

        if (halt_q | dstall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (istall) begin
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_mem_sched.sv
// tb_pipe_mem_sched: table-driven stall decode, directed memory sequences and
// randomized request scenarios against a fixed-latency memory model.
module tb_pipe_mem_sched;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_blk_addr, d_blk_addr, d_wr_addr, d_wr_data;
    logic        mem_rd_valid;
    logic        ex_mem_read, id_uses_rt, br_taken, wb_halt;
    logic [3:0]  ex_dst, id_rs, id_rt;
    logic        mem_en, mem_wr, fill_we, fill_tgt;
    logic [15:0] mem_addr, mem_wdata;
    logic [2:0]  fill_idx;
    logic        i_fill_done, d_fill_done, d_wr_ack;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic        if_id_flush, id_ex_bubble;

    always #5 clk = ~clk;

    pipe_mem_sched #(.BLK_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_blk_addr(i_blk_addr),
        .d_miss(d_miss), .d_blk_addr(d_blk_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_rd_valid(mem_rd_valid),
        .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .br_taken(br_taken), .wb_halt(wb_halt),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fill_we(fill_we), .fill_tgt(fill_tgt), .fill_idx(fill_idx),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble)
    );

    // Fixed-latency pipelined memory: each read strobe returns valid LAT cycles later.
    logic [LAT-1:0] vpipe = '0;
    always @(posedge clk) vpipe <= {vpipe[LAT-2:0], mem_en & ~mem_wr};
    assign mem_rd_valid = vpipe[LAT-1];

    int n_vec = 0;
    int n_err = 0;
    int unsigned cyc = 0;
    bit chk_en = 1'b0;

    logic [15:0]  rd_q[$];
    int unsigned  rd_cyc_q[$];
    logic [31:0]  st_q[$];
    logic [3:0]   fw_q[$];
    logic         done_q[$];
    int unsigned  st_cyc, i_done_cyc;
    int           ack_bad;
    logic [6:0]   en_now;
    logic         dm_now, im_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Expected {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble} from the priority rules.
    function automatic logic [6:0] exp_en(input logic halt, input logic dstall,
                                          input logic br, input logic lu, input logic istall);
        if (halt || dstall) return 7'b0000000;
        if (br)             return 7'b1111111;
        if (lu)             return 7'b0011101;
        if (istall)         return 7'b0111110;
        return 7'b1111100;
    endfunction

    task automatic clear_logs();
        rd_q.delete(); rd_cyc_q.delete(); st_q.delete(); fw_q.delete(); done_q.delete();
        ack_bad = 0; st_cyc = 0; i_done_cyc = 0;
    endtask

    // One clock: sample at the falling edge, log memory events, act as requesters.
    task automatic tick();
        logic       lu_v;
        logic [6:0] e;
        @(negedge clk);
        cyc++;
        en_now = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                  if_id_flush, id_ex_bubble};
        im_now = i_miss;
        dm_now = d_miss;
        if (chk_en) begin
            lu_v = ex_mem_read && ex_dst != 4'd0 &&
                   (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
            e = exp_en(1'b0, d_miss | d_wr_req, br_taken, lu_v, i_miss);
            chk("stage_ctl", 32'(en_now), 32'(e));
        end
        if (mem_en && !mem_wr) begin rd_q.push_back(mem_addr); rd_cyc_q.push_back(cyc); end
        if (mem_en && mem_wr) begin st_q.push_back({mem_addr, mem_wdata}); st_cyc = cyc; end
        if (d_wr_ack !== (mem_en & mem_wr)) ack_bad++;
        if (fill_we) fw_q.push_back({fill_tgt, fill_idx});
        if (i_fill_done) begin done_q.push_back(1'b0); i_done_cyc = cyc; i_miss = 1'b0; end
        if (d_fill_done) begin done_q.push_back(1'b1); d_miss = 1'b0; end
        if (d_wr_ack) d_wr_req = 1'b0;
    endtask

    // Line fills in order: 8 consecutive reads from base, 8 fills idx 0..7, one done each.
    task automatic check_lines(input string tag, input int nl,
                               input logic [15:0] b0, input logic t0,
                               input logic [15:0] b1, input logic t1);
        logic [15:0] b;
        logic        t;
        chk({tag, "_nreads"}, 32'(rd_q.size()), 32'(8 * nl));
        chk({tag, "_nfills"}, 32'(fw_q.size()), 32'(8 * nl));
        chk({tag, "_ndone"},  32'(done_q.size()), 32'(nl));
        chk({tag, "_ack"},    32'(ack_bad), 32'd0);
        for (int l = 0; l < nl; l++) begin
            b = (l == 0) ? b0 : b1;
            t = (l == 0) ? t0 : t1;
            if (rd_q.size() >= 8 * nl) begin
                for (int j = 0; j < 8; j++)
                    chk($sformatf("%s_addr%0d_%0d", tag, l, j), 32'(rd_q[8*l+j]),
                        32'(16'(b + 16'(2 * j))));
                chk($sformatf("%s_burst%0d", tag, l),
                    32'(rd_cyc_q[8*l+7] - rd_cyc_q[8*l]), 32'd7);
            end
            if (fw_q.size() >= 8 * nl)
                for (int j = 0; j < 8; j++)
                    chk($sformatf("%s_fill%0d_%0d", tag, l, j), 32'(fw_q[8*l+j]),
                        32'({t, 3'(j)}));
            if (done_q.size() >= nl)
                chk($sformatf("%s_done%0d", tag, l), 32'(done_q[l]), 32'(t));
        end
    endtask

    typedef struct {
        logic       dm, dw, im, emr;
        logic [3:0] exd, rs, rt;
        logic       urt, br;
        logic [6:0] exp_v;
    } vec_t;

    vec_t vt[13];

    initial begin
        int unsigned t;
        int          bad;

        vt[0]  = '{1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,7'b1111100};
        vt[1]  = '{1'b0,1'b0,1'b0,1'b1,4'd3,4'd3,4'd0,1'b0,1'b0,7'b0011101};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b1,4'd0,4'd0,4'd0,1'b1,1'b0,7'b1111100};
        vt[3]  = '{1'b0,1'b0,1'b0,1'b1,4'd5,4'd1,4'd5,1'b1,1'b0,7'b0011101};
        vt[4]  = '{1'b0,1'b0,1'b0,1'b1,4'd5,4'd1,4'd5,1'b0,1'b0,7'b1111100};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b0,4'd3,4'd3,4'd0,1'b0,1'b0,7'b1111100};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b1,4'd3,4'd3,4'd0,1'b0,1'b1,7'b1111111};
        vt[7]  = '{1'b0,1'b0,1'b1,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,7'b0111110};
        vt[8]  = '{1'b0,1'b0,1'b1,1'b1,4'd3,4'd3,4'd0,1'b0,1'b0,7'b0011101};
        vt[9]  = '{1'b0,1'b0,1'b1,1'b0,4'd0,4'd0,4'd0,1'b0,1'b1,7'b1111111};
        vt[10] = '{1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b1,7'b0000000};
        vt[11] = '{1'b0,1'b1,1'b0,1'b1,4'd3,4'd3,4'd0,1'b0,1'b0,7'b0000000};
        vt[12] = '{1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,7'b0000000};

        rst = 1'b1;
        i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_blk_addr = '0; d_blk_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        ex_mem_read = 1'b0; ex_dst = '0; id_rs = '0; id_rt = '0;
        id_uses_rt = 1'b0; br_taken = 1'b0; wb_halt = 1'b0;
        clear_logs();
        repeat (4) @(negedge clk);

        // Reset holds the FSM in IDLE, so the stall decode can be driven freely.
        for (int k = 0; k < 13; k++) begin
            d_miss = vt[k].dm; d_wr_req = vt[k].dw; i_miss = vt[k].im;
            ex_mem_read = vt[k].emr; ex_dst = vt[k].exd; id_rs = vt[k].rs;
            id_rt = vt[k].rt; id_uses_rt = vt[k].urt; br_taken = vt[k].br;
            @(negedge clk);
            chk($sformatf("vec%0d_en", k),
                32'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                     if_id_flush, id_ex_bubble}), 32'(vt[k].exp_v));
            chk($sformatf("vec%0d_rstregs", k),
                32'({mem_en, mem_wr, fill_we, i_fill_done, d_fill_done, d_wr_ack, mem_addr}),
                32'd0);
        end
        d_miss = 1'b0; d_wr_req = 1'b0; i_miss = 1'b0;
        ex_mem_read = 1'b0; ex_dst = '0; id_rs = '0; id_rt = '0;
        id_uses_rt = 1'b0; br_taken = 1'b0;
        rst = 1'b0;
        repeat (LAT + 2) tick();
        chk_en = 1'b1;

        // I-line fill from 0x0040, PC frozen while the miss is pending.
        clear_logs();
        i_blk_addr = 16'h0040; i_miss = 1'b1;
        t = 0; bad = 0;
        while (i_miss && t < 100) begin
            tick(); t++;
            if (im_now && en_now[6]) bad++;
        end
        chk("ifill_timeout", 32'(i_miss), 32'd0);
        repeat (6) tick();
        chk("ifill_pc_frozen", 32'(bad), 32'd0);
        check_lines("ifill", 1, 16'h0040, 1'b0, 16'h0000, 1'b0);

        // Simultaneous misses: D line first, pipeline frozen until D done.
        clear_logs();
        d_blk_addr = 16'h0200; i_blk_addr = 16'h0300;
        d_miss = 1'b1; i_miss = 1'b1;
        t = 0; bad = 0;
        while ((d_miss || i_miss) && t < 150) begin
            tick(); t++;
            if (dm_now && en_now[6:2] != 5'd0) bad++;
        end
        chk("both_timeout", 32'(d_miss | i_miss), 32'd0);
        repeat (6) tick();
        chk("both_dfreeze", 32'(bad), 32'd0);
        check_lines("both", 2, 16'h0200, 1'b1, 16'h0300, 1'b0);

        // Store raised during an I-fill is issued right after i_fill_done.
        clear_logs();
        i_blk_addr = 16'h0100; i_miss = 1'b1;
        tick(); tick();
        d_wr_addr = 16'h1234; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
        t = 0;
        while ((d_wr_req || i_miss) && t < 150) begin tick(); t++; end
        chk("st_timeout", 32'(d_wr_req | i_miss), 32'd0);
        repeat (6) tick();
        chk("st_count", 32'(st_q.size()), 32'd1);
        if (st_q.size() == 1) chk("st_addr_data", st_q[0], 32'h1234BEEF);
        chk("st_after_idone", st_cyc, i_done_cyc + 1);
        check_lines("stfill", 1, 16'h0100, 1'b0, 16'h0000, 1'b0);

        // Halt freeze, then reset in the middle of a fill.
        chk_en = 1'b0;
        clear_logs();
        i_blk_addr = 16'h0080; i_miss = 1'b1; wb_halt = 1'b1;
        tick();
        wb_halt = 1'b0;
        bad = (en_now[6:2] != 5'd0) ? 1 : 0;
        t = 0;
        while (fw_q.size() < 4 && t < 60) begin
            tick(); t++;
            if (en_now[6:2] != 5'd0) bad++;
        end
        chk("halt_reach_word3", 32'(fw_q.size()), 32'd4);
        chk("halt_freeze", 32'(bad), 32'd0);
        rst = 1'b1; i_miss = 1'b0;
        tick();
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (mem_en || fill_we || i_fill_done || d_fill_done) bad++;
        end
        chk("rst_abandon_quiet", 32'(bad), 32'd0);
        chk("rst_abandon_done", 32'(done_q.size()), 32'd0);
        chk("rst_abandon_fills", 32'(fw_q.size()), 32'd4);
        chk("rst_halt_cleared", 32'(en_now), 32'(7'b1111100));
        chk_en = 1'b1;

        // Randomized request scenarios with random pipeline hazards.
        for (int it = 0; it < 30; it++) begin
            logic        us, ud, ui, up_s, up_d, up_i, d_first;
            int unsigned ds, dd, di, c;
            logic [15:0] sa, sd, bd, bi;
            clear_logs();
            us = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            ui = 1'($urandom_range(0, 1));
            if (!us && !ud && !ui) ui = 1'b1;
            if (us && ud && ui) begin
                if ($urandom_range(0, 1) == 0) ud = 1'b0; else ui = 1'b0;
            end
            ds = $urandom_range(0, 10);
            dd = $urandom_range(0, 10);
            di = $urandom_range(0, 10);
            sa = 16'($urandom); sd = 16'($urandom);
            bd = {12'($urandom), 4'h0};
            bi = {12'($urandom), 4'h0};
            up_s = 1'b0; up_d = 1'b0; up_i = 1'b0;
            c = 0;
            while (c < 200 && !((!us || up_s) && (!ud || up_d) && (!ui || up_i) &&
                                !d_wr_req && !d_miss && !i_miss)) begin
                if (us && !up_s && c == ds) begin
                    d_wr_addr = sa; d_wr_data = sd; d_wr_req = 1'b1; up_s = 1'b1;
                end
                if (ud && !up_d && c == dd) begin d_blk_addr = bd; d_miss = 1'b1; up_d = 1'b1; end
                if (ui && !up_i && c == di) begin i_blk_addr = bi; i_miss = 1'b1; up_i = 1'b1; end
                ex_mem_read = 1'($urandom_range(0, 1));
                ex_dst      = 4'($urandom_range(0, 3));
                id_rs       = 4'($urandom_range(0, 3));
                id_rt       = 4'($urandom_range(0, 3));
                id_uses_rt  = 1'($urandom_range(0, 1));
                br_taken    = ($urandom_range(0, 7) == 0);
                tick();
                c++;
            end
            chk($sformatf("rand%0d_timeout", it), 32'(c < 200), 32'd1);
            repeat (6) tick();
            chk($sformatf("rand%0d_st_count", it), 32'(st_q.size()), 32'(us));
            if (us && st_q.size() == 1)
                chk($sformatf("rand%0d_st", it), st_q[0], {sa, sd});
            d_first = (dd <= di);
            if (ud && ui) begin
                if (d_first) check_lines($sformatf("rand%0d", it), 2, bd, 1'b1, bi, 1'b0);
                else         check_lines($sformatf("rand%0d", it), 2, bi, 1'b0, bd, 1'b1);
            end else if (ud) begin
                check_lines($sformatf("rand%0d", it), 1, bd, 1'b1, 16'h0000, 1'b0);
            end else if (ui) begin
                check_lines($sformatf("rand%0d", it), 1, bi, 1'b0, 16'h0000, 1'b0);
            end else begin
                check_lines($sformatf("rand%0d", it), 0, 16'h0000, 1'b0, 16'h0000, 1'b0);
            end
        end
        ex_mem_read = 1'b0; br_taken = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
